// File: rtl/wb_lbp_ctrl.sv
// wb_lbp_ctrl: Wishbone regs (wbs_*), start/done controller (core_start/core_done/irq), channel outputs (core_ce/core_data/core_sel) and result FIFO (core_result)
module wb_lbp_ctrl #(
  parameter logic [3:0] BASE = 4'h3,
  parameter int NCH = 3,
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            core_start,
  output logic [NCH-1:0]  core_ce,
  output logic [NCH*DW-1:0] core_data,
  output logic [1:0]      core_sel,
  input  logic            core_done,
  input  logic [DW-1:0]   core_result,
  output logic            irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic ack_q, start_q, irq_en_q, done_q, ovf_q;
  logic [31:0] dat_q;
  logic [NCH-1:0] ce_q;
  logic [1:0] sel_q;
  logic [DW-1:0] data_q [NCH];
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic acc, wr, rd, empty, full, push, push_ok, pop, start, w1c;
  logic [7:0] off;
  logic [31:0] wmask, rdata;
  logic unused_ok;
  assign off = wbs_adr_i[7:0];
  assign acc = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE) & ~ack_q;
  assign wr = acc & wbs_we_i;
  assign rd = acc & ~wbs_we_i;
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign push = core_done & (state_q == RUN);
  assign pop = rd & (off == 8'h10) & ~empty;
  assign push_ok = push & (~full | pop);
  assign start = wr & (off == 8'h00) & wbs_sel_i[0] & wbs_dat_i[0] & (state_q == IDLE);
  assign w1c = wr & (off == 8'h0C) & wbs_sel_i[0];
  assign unused_ok = &{1'b0, wbs_adr_i[27:8], wbs_dat_i, wmask};
  always_comb begin
    rdata = '0;
    if (off == 8'h00) rdata[1] = irq_en_q;
    if (off == 8'h04) rdata[NCH-1:0] = ce_q;
    if (off == 8'h08) rdata[1:0] = sel_q;
    if (off == 8'h0C) rdata[12:0] = {5'(cnt_q), 3'b000, ovf_q, full, empty, done_q, state_q == RUN};
    if (off == 8'h10 && !empty) rdata[DW-1:0] = mem_q[rd_q];
    for (int i = 0; i < NCH; i++)
      if (off == 8'(32 + 4 * i)) rdata[DW-1:0] = data_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      dat_q <= '0;
      start_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      ce_q <= '0;
      sel_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NCH; i++) data_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= wbs_we_i ? '0 : rdata;
      start_q <= start;
      state_q <= start ? RUN : push ? IDLE : state_q;
      if (wr && off == 8'h00 && wbs_sel_i[0]) irq_en_q <= wbs_dat_i[1];
      if (wr && off == 8'h04) ce_q <= (ce_q & ~wmask[NCH-1:0]) | (wbs_dat_i[NCH-1:0] & wmask[NCH-1:0]);
      if (wr && off == 8'h08 && wbs_sel_i[0]) sel_q <= wbs_dat_i[1:0];
      for (int i = 0; i < NCH; i++)
        if (wr && off == 8'(32 + 4 * i))
          data_q[i] <= (data_q[i] & ~wmask[DW-1:0]) | (wbs_dat_i[DW-1:0] & wmask[DW-1:0]);
      done_q <= push | (done_q & ~(w1c & wbs_dat_i[1]));
      ovf_q <= (push & full & ~pop) | (ovf_q & ~(w1c & wbs_dat_i[4]));
      if (push_ok) begin
        mem_q[wr_q] <= core_result;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_data
    assign core_data[g*DW +: DW] = data_q[g];
  end
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign core_start = start_q;
  assign core_ce = ce_q;
  assign core_sel = sel_q;
  assign irq = done_q & irq_en_q;
endmodule

// File: tb/tb_wb_lbp_ctrl.sv
// tb_wb_lbp_ctrl: directed self-checking bench for wb_lbp_ctrl
module tb_wb_lbp_ctrl;
  localparam logic [3:0] BASE = 4'h3;
  logic clk = 0, rst = 1;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat_i = 0, dat_o;
  logic ack, core_start, core_done = 0, irq;
  logic [2:0] core_ce;
  logic [23:0] core_data;
  logic [1:0] core_sel;
  logic [7:0] core_result = 0;
  int errors = 0, checks = 0;
  logic [31:0] q;
  wb_lbp_ctrl dut (
    .clk(clk), .rst(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack),
    .wbs_dat_o(dat_o), .core_start(core_start), .core_ce(core_ce),
    .core_data(core_data), .core_sel(core_sel), .core_done(core_done),
    .core_result(core_result), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] off, input logic w, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n;
    n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = {BASE, 20'h0, off}; dat_i = d; sel = s;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    if (!ack) chk("ack_timeout", 32'(ack), 1);
    r = dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    xfer(off, 1, d, s, r);
  endtask
  task automatic wb_rd(input logic [7:0] off, output logic [31:0] r);
    xfer(off, 0, 0, 4'hF, r);
  endtask
  task automatic done_pulse(input logic [7:0] r);
    @(negedge clk);
    core_done = 1; core_result = r;
    @(negedge clk);
    core_done = 0;
  endtask
  task automatic conc_rd(input logic [7:0] r, output logic [31:0] v);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = {BASE, 20'h0, 8'h10}; sel = 4'hF;
    core_done = 1; core_result = r;
    @(negedge clk);
    core_done = 0;
    chk("conc_ack", 32'(ack), 1);
    v = dat_o;
    cyc = 0; stb = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_ce", 32'(core_ce), 0);
    chk("rst_data", 32'(core_data), 0);
    chk("rst_irq", 32'(irq), 0);
    wb_rd(8'h0C, q); chk("rst_status", q, 32'h4);
    wb_wr(8'h28, 32'hA5, 4'hF);
    chk("data2_out", 32'(core_data), 32'hA50000);
    wb_rd(8'h28, q); chk("data2_rd", q, 32'hA5);
    wb_wr(8'h24, 32'hFFFF_FF5A, 4'hF);
    wb_rd(8'h24, q); chk("data1_rd", q, 32'h5A);
    wb_wr(8'h20, 32'h1234, 4'b0010);
    wb_rd(8'h20, q); chk("data0_bytemask", q, 0);
    wb_wr(8'h04, 32'h7, 4'b0000);
    wb_rd(8'h04, q); chk("ce_sel0", q, 0);
    wb_wr(8'h04, 32'h5, 4'b0001);
    wb_rd(8'h04, q); chk("ce_rd", q, 5);
    chk("ce_out", 32'(core_ce), 5);
    wb_wr(8'h08, 32'h2, 4'hF);
    wb_rd(8'h08, q); chk("sel_rd", q, 2);
    chk("sel_out", 32'(core_sel), 2);
    wb_wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    wb_rd(8'h40, q); chk("unmapped", q, 0);
    wb_wr(8'h00, 32'h3, 4'hF);
    chk("start_hi", 32'(core_start), 1);
    @(negedge clk); chk("start_lo", 32'(core_start), 0);
    wb_rd(8'h0C, q); chk("busy", q, 32'h5);
    wb_wr(8'h00, 32'h3, 4'hF);
    chk("start_busy", 32'(core_start), 0);
    @(negedge clk); chk("start_busy2", 32'(core_start), 0);
    done_pulse(8'h3C);
    chk("irq_set", 32'(irq), 1);
    wb_rd(8'h0C, q); chk("status_done", q, 32'h102);
    wb_rd(8'h10, q); chk("result", q, 32'h3C);
    wb_rd(8'h0C, q); chk("status_empty", q, 32'h6);
    wb_rd(8'h00, q); chk("ctrl_rd", q, 32'h2);
    wb_wr(8'h0C, 32'h2, 4'hF);
    chk("irq_clr", 32'(irq), 0);
    wb_rd(8'h0C, q); chk("status_clr", q, 32'h4);
    done_pulse(8'h77);
    wb_rd(8'h0C, q); chk("idle_done", q, 32'h4);
    for (int r = 1; r <= 5; r++) begin
      wb_wr(8'h00, 32'h3, 4'hF);
      done_pulse(8'(r));
    end
    wb_rd(8'h0C, q); chk("status_ovf", q, 32'h41A);
    wb_wr(8'h0C, 32'h12, 4'hF);
    wb_rd(8'h0C, q); chk("status_w1c", q, 32'h408);
    wb_wr(8'h00, 32'h3, 4'hF);
    conc_rd(8'h06, q); chk("conc_full_rd", q, 1);
    wb_rd(8'h0C, q); chk("conc_full_status", q, 32'h40A);
    wb_rd(8'h10, q); chk("drain0", q, 2);
    wb_rd(8'h10, q); chk("drain1", q, 3);
    wb_rd(8'h10, q); chk("drain2", q, 4);
    wb_rd(8'h10, q); chk("drain3", q, 6);
    wb_rd(8'h10, q); chk("drain_empty", q, 0);
    wb_rd(8'h0C, q); chk("status_drained", q, 32'h6);
    wb_wr(8'h00, 32'h3, 4'hF);
    conc_rd(8'h55, q); chk("conc_empty_rd", q, 0);
    wb_rd(8'h0C, q); chk("conc_empty_status", q, 32'h102);
    wb_rd(8'h10, q); chk("conc_empty_pop", q, 32'h55);
    wb_wr(8'h0C, 32'h2, 4'hF);
    wb_wr(8'h00, 32'h3, 4'hF);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    done_pulse(8'h99);
    wb_rd(8'h0C, q); chk("rst_mid_status", q, 32'h4);
    chk("rst_mid_irq", 32'(irq), 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = {BASE, 20'h0, 8'h0C}; sel = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("ack_cyc%0d", c), 32'(ack), 32'(c % 2 == 0));
      @(negedge clk);
    end
    cyc = 0; stb = 0;
    @(negedge clk);
    begin
      logic seen;
      seen = 0;
      cyc = 1; stb = 1; adr = {4'h2, 20'h0, 8'h0C};
      repeat (4) begin @(negedge clk); seen |= ack; end
      cyc = 0; stb = 0;
      chk("tag_mismatch", 32'(seen), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
